// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined segment adder: mode encodings and
// segment-geometry helpers used at elaboration time.
package adder_pkg;

  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;

  // Width of one carry-chained segment; guarded so a bad SEGS cannot divide by zero.
  function automatic int unsigned seg_width(input int unsigned width, input int unsigned segs);
    if (segs == 0) begin
      return width;
    end
    return width / segs;
  endfunction

  function automatic bit cfg_ok(input int unsigned width, input int unsigned segs);
    return (segs >= 1) && (segs <= width) && ((width % segs) == 0);
  endfunction

endpackage

// File: rtl/adder_segment.sv
// One SEG_W-bit slice of the carry chain. Purely combinational; the parent
// stage registers sum and carry.
module adder_segment #(
  parameter int unsigned SEG_W = 8
) (
  input  logic [SEG_W-1:0] i_a,
  input  logic [SEG_W-1:0] i_b,
  input  logic             i_cin,
  output logic [SEG_W-1:0] o_sum,
  output logic             o_cout,
  output logic             o_cin_msb
);

  localparam int unsigned EXT_W = SEG_W + 1;

  logic [SEG_W:0] full_c;

  always_comb begin
    full_c    = {1'b0, i_a} + {1'b0, i_b} + EXT_W'(i_cin);
    o_sum     = full_c[SEG_W-1:0];
    o_cout    = full_c[SEG_W];
    // Carry into the top bit is recovered from the top sum bit and its operands.
    o_cin_msb = full_c[SEG_W-1] ^ i_a[SEG_W-1] ^ i_b[SEG_W-1];
  end

endmodule

// File: rtl/pipelined_segment_adder.sv
// Valid/ready pipelined adder/subtractor: one SEG_W-bit segment per stage,
// operands skewed into the pipe and partial sums de-skewed on the way out.
module pipelined_segment_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SEGS  = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  input  logic             i_sub,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ovf,
  output logic             o_zero
);

  localparam int unsigned SEG_W = seg_width(WIDTH, SEGS);

  if (!cfg_ok(WIDTH, SEGS)) begin : g_cfg_check
    $error("pipelined_segment_adder: WIDTH must be a multiple of SEGS with 1 <= SEGS <= WIDTH");
  end

  logic             adv_c;
  logic [WIDTH-1:0] b_in_c;
  logic             cin0_c;

  logic [SEG_W-1:0] seg_a    [SEGS];
  logic [SEG_W-1:0] seg_b    [SEGS];
  logic             seg_cin  [SEGS];
  logic [SEG_W-1:0] seg_sum  [SEGS];
  logic             seg_cout [SEGS];
  logic             seg_cmsb [SEGS];

  logic             vld_d  [SEGS];
  logic             vld_q  [SEGS];
  logic             cy_d   [SEGS];
  logic             cy_q   [SEGS];
  logic             ovf_d  [SEGS];
  logic             ovf_q  [SEGS];
  logic             zero_d [SEGS];
  logic             zero_q [SEGS];
  logic [WIDTH-1:0] sum_d  [SEGS];
  logic [WIDTH-1:0] sum_q  [SEGS];
  logic [WIDTH-1:0] a_d    [SEGS];
  logic [WIDTH-1:0] a_q    [SEGS];
  logic [WIDTH-1:0] b_d    [SEGS];
  logic [WIDTH-1:0] b_q    [SEGS];

  // Whole pipe moves together; a stalled output freezes every stage.
  always_comb begin
    adv_c  = ~vld_q[SEGS-1] | i_ready;
    b_in_c = (i_sub == SUB) ? ~i_b : i_b;
    cin0_c = (i_sub == ADD) ? i_cin : 1'b1;
  end

  // Segment operands: stage 0 from the ports, later stages from the skew registers.
  always_comb begin
    for (int unsigned k = 0; k < SEGS; k++) begin
      seg_a[k]   = '0;
      seg_b[k]   = '0;
      seg_cin[k] = 1'b0;
    end
    seg_a[0]   = i_a[SEG_W-1:0];
    seg_b[0]   = b_in_c[SEG_W-1:0];
    seg_cin[0] = cin0_c;
    for (int unsigned k = 1; k < SEGS; k++) begin
      seg_a[k]   = a_q[k-1][k*SEG_W +: SEG_W];
      seg_b[k]   = b_q[k-1][k*SEG_W +: SEG_W];
      seg_cin[k] = cy_q[k-1];
    end
  end

  for (genvar k = 0; k < SEGS; k++) begin : g_seg
    adder_segment #(
      .SEG_W (SEG_W)
    ) u_seg (
      .i_a       (seg_a[k]),
      .i_b       (seg_b[k]),
      .i_cin     (seg_cin[k]),
      .o_sum     (seg_sum[k]),
      .o_cout    (seg_cout[k]),
      .o_cin_msb (seg_cmsb[k])
    );
  end

  // Next-state for every stage; lower sums ride along so the last stage holds all bits.
  always_comb begin
    for (int unsigned k = 0; k < SEGS; k++) begin
      vld_d[k] = 1'b0;
      a_d[k]   = '0;
      b_d[k]   = '0;
      sum_d[k] = '0;
    end
    vld_d[0]            = i_valid;
    a_d[0]              = i_a;
    b_d[0]              = b_in_c;
    sum_d[0][SEG_W-1:0] = seg_sum[0];
    for (int unsigned k = 1; k < SEGS; k++) begin
      vld_d[k]                   = vld_q[k-1];
      a_d[k]                     = a_q[k-1];
      b_d[k]                     = b_q[k-1];
      sum_d[k]                   = sum_q[k-1];
      sum_d[k][k*SEG_W +: SEG_W] = seg_sum[k];
    end
    for (int unsigned k = 0; k < SEGS; k++) begin
      cy_d[k]   = seg_cout[k];
      ovf_d[k]  = seg_cout[k] ^ seg_cmsb[k];
      zero_d[k] = ~|sum_d[k];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned k = 0; k < SEGS; k++) begin
        vld_q[k]  <= 1'b0;
        cy_q[k]   <= 1'b0;
        ovf_q[k]  <= 1'b0;
        zero_q[k] <= 1'b0;
        sum_q[k]  <= '0;
        a_q[k]    <= '0;
        b_q[k]    <= '0;
      end
    end else if (adv_c) begin
      for (int unsigned k = 0; k < SEGS; k++) begin
        vld_q[k]  <= vld_d[k];
        cy_q[k]   <= cy_d[k];
        ovf_q[k]  <= ovf_d[k];
        zero_q[k] <= zero_d[k];
        sum_q[k]  <= sum_d[k];
        a_q[k]    <= a_d[k];
        b_q[k]    <= b_d[k];
      end
    end
  end

  always_comb begin
    o_ready = adv_c;
    o_valid = vld_q[SEGS-1];
    o_sum   = sum_q[SEGS-1];
    o_cout  = cy_q[SEGS-1];
    o_ovf   = ovf_q[SEGS-1];
    o_zero  = zero_q[SEGS-1];
  end

endmodule

// File: doc/pipelined_segment_adder.md
# pipelined_segment_adder

Parametrised, pipelined two-operand adder/subtractor that splits a WIDTH-bit operation into SEGS carry-chained segments, one segment per pipeline stage, so the design closes timing at wide widths with a single short carry chain per stage. Sits between operand producers and result consumers on a valid/ready stream and replaces the purely combinational 32-bit adders for wide or high-frequency datapaths. Adds carry-in, subtract mode, carry-out, signed-overflow and zero flags, and backpressure.

## Interface
- WIDTH, 32, operand/result width; must be a multiple of SEGS.
- SEGS, 4, number of segments = pipeline stages = latency in cycles; 1 ≤ SEGS ≤ WIDTH.
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst  input  1  reset, synchronous, active-high.
- i_valid  input  1  operand beat valid.
- o_ready  output  1  block can accept a beat this cycle.
- i_a  input  WIDTH  operand A.
- i_b  input  WIDTH  operand B.
- i_cin  input  1  carry-in; ignored when i_sub=1.
- i_sub  input  1  0: A+B+cin; 1: A−B (A+~B+1).
- o_valid  output  1  result beat valid.
- i_ready  input  1  consumer accepts result this cycle.
- o_sum  output  WIDTH  result.
- o_cout  output  1  carry out of MSB (for subtract: 1 = no borrow).
- o_ovf  output  1  signed two's-complement overflow.
- o_zero  output  1  o_sum == 0.

## Operation
- SEG_W = WIDTH/SEGS. Stage k (0..SEGS−1) adds bits [k·SEG_W +: SEG_W] of A and B' (B' = i_sub ? ~B : B) plus carry from stage k−1 (stage 0 carry = i_sub ? 1 : i_cin).
- Input skew: on acceptance, upper segments of A, B' are registered and walk down the pipe alongside the beat; stage k consumes its segment only when the beat reaches it.
- Output de-skew: completed lower-segment sums travel with the beat so all WIDTH bits present simultaneously at the last stage.
- Carry between stages is registered (one flop per stage boundary).
- o_cout = carry out of final segment; o_ovf = carry into MSB XOR carry out of MSB; o_zero = ~|o_sum. All computed/registered so they are valid with o_valid.
- Each stage holds a valid bit. Global advance enable: adv = ~o_valid | i_ready. o_ready = adv. When adv=0 every stage holds (no bubble collapse). Beat accepted iff i_valid & o_ready.
- Order strictly preserved; no drop, no duplication.

## Timing
- Latency: beat accepted at edge t appears with o_valid=1 after edge t+SEGS−1 (i.e., SEGS register stages), assuming no stall; each stall cycle adds one.
- Throughput: one beat per cycle while i_ready=1.
- Reset (i_rst=1 at an edge): all stage valid bits and o_valid → 0; o_sum, o_cout, o_ovf, o_zero → 0; o_ready=1 in the cycle after reset. In-flight beats discarded and never emerge. i_valid during reset ignored.
- Result held stable on o_* while o_valid & ~i_ready.
- Simultaneous output consume and input accept in one cycle is legal at full rate.
- SEGS=1: single registered WIDTH-bit adder, latency 1, same handshake.
- Wrap-around: sum is modulo 2^WIDTH; carry reported only via o_cout.

## Structure
- Shared package adder_pkg: mode constants ADD=1'b0, SUB=1'b1; function computing SEG_W; elaboration-time check that WIDTH % SEGS == 0.
- One sub-module: adder_segment (SEG_W-bit add with carry-in/out and carry-into-MSB output; combinational, registered by the parent stage), instantiated SEGS times via generate.
- Parent holds skew/de-skew registers, valid chain, flag logic.

## Test plan
- WIDTH=32, SEGS=4: A=0xFFFFFFFF, B=0x00000001, cin=0, add → after 4 cycles o_sum=0x00000000, o_cout=1, o_ovf=0, o_zero=1.
- A=0x7FFFFFFF, B=0x00000001, add → o_sum=0x80000000, o_cout=0, o_ovf=1, o_zero=0; A=0x00000005, B=0x00000007, sub → o_sum=0xFFFFFFFE, o_cout=0, o_ovf=0.
- Stream 8 beats back-to-back (A=i, B=0x10·i), drop i_ready for 3 cycles after the second result → 8 results in order, values exact, o_sum stable during stall, o_ready=0 during stall.
- 3 beats in flight, assert i_rst one cycle → next cycle o_valid=0, all outputs 0; none of the 3 results ever appear; a new beat after reset emerges in 4 cycles.
- cin=1 with add: A=0x0000FFFF, B=0 → o_sum=0x00010000 (carry crosses segment boundary); cin=1 with sub ignored: A=3, B=3 → o_sum=0, o_zero=1, o_cout=1.
- Random 10k beats with random i_valid/i_ready vs reference model at (WIDTH,SEGS) = (32,4), (16,2), (64,8), (8,1) → zero mismatches, no lost/duplicated beats.
